// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit. It has no adder
// of its own. It borrows the core's shared 32-bit ALU for every arithmetic
// step: operand absolute values, 32 shift-add or restoring-divide iterations,
// and a final negation pass. Accept-to-result latency is 35 cycles for every op.
//
// Ports
//   clk, rst_n           core clock, synchronous active-low reset
//   in_valid/in_ready    operation handshake (ready only when idle)
//   in_op                RV32M funct3
//   in_a, in_b           rs1, rs2
//   out_valid/out_ready  result handshake; the result is held until accepted
//   out_result           final value
//   out_illegal          op was MULH/MULHSU (result forced to 0)
//   alu_control          shared ALU opcode (000 add, 001 sub)
//   alu_src_a/b          shared ALU operands
//   alu_result/carry     shared ALU sum and carry-out
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_illegal,
  output logic [2:0]  alu_control,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  input  logic [31:0] alu_result,
  input  logic        alu_carry
);

  typedef enum logic [2:0] {S_IDLE, S_ABS_A, S_ABS_B, S_ITER, S_FIX, S_DONE} state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_a;    // operand a, later the multiplicand
  logic [31:0] r_b;    // operand b, later the divisor
  logic [31:0] r_lo;   // multiply: low product / divide: quotient
  logic [31:0] r_hi;   // multiply: high product / divide: remainder
  logic [5:0]  r_cnt;
  logic        r_sa, r_sb, r_bz;
  logic [31:0] r_res;
  logic        r_ill;

  logic        w_is_mul, w_sdiv, w_q, w_fix_neg, w_fix_ill;
  logic [31:0] w_sh, w_bnew, w_fix_val;

  assign w_is_mul = ~r_op[2];
  assign w_sdiv   = r_op[2] & ~r_op[0];          // DIV or REM
  assign w_sh     = {r_hi[30:0], r_lo[31]};
  // The remainder is really 33 bits wide. A set r_hi[31] means the shifted
  // value already exceeds any 32-bit divisor.
  assign w_q      = r_hi[31] | alu_carry;
  assign w_bnew   = (w_sdiv && r_b[31]) ? alu_result : r_b;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_result  = r_res;
  assign out_illegal = r_ill;

  always_comb begin
    w_next      = r_state;
    alu_control = ALU_ADD;
    alu_src_a   = '0;
    alu_src_b   = '0;
    w_fix_val   = '0;
    w_fix_neg   = 1'b0;
    w_fix_ill   = 1'b0;

    case (r_op)
      3'b000: w_fix_val = r_lo;
      3'b011: w_fix_val = r_hi;
      3'b100: begin w_fix_val = r_lo; w_fix_neg = (r_sa ^ r_sb) & ~r_bz; end
      3'b101: w_fix_val = r_lo;
      3'b110: begin w_fix_val = r_hi; w_fix_neg = r_sa; end
      3'b111: w_fix_val = r_hi;
      default: w_fix_ill = 1'b1;
    endcase

    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ABS_A;
      S_ABS_A: begin
        alu_control = ALU_SUB;
        alu_src_b   = r_a;
        w_next      = S_ABS_B;
      end
      S_ABS_B: begin
        alu_control = ALU_SUB;
        alu_src_b   = r_b;
        w_next      = S_ITER;
      end
      S_ITER: begin
        if (w_is_mul) begin
          alu_control = ALU_ADD;
          alu_src_a   = r_hi;
          alu_src_b   = r_lo[0] ? r_a : '0;
        end else begin
          alu_control = ALU_SUB;
          alu_src_a   = w_sh;
          alu_src_b   = r_b;
        end
        if (r_cnt == 6'd31) w_next = S_FIX;
      end
      S_FIX: begin
        alu_control = ALU_SUB;
        alu_src_b   = w_fix_val;
        w_next      = S_DONE;
      end
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_cnt   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_bz    <= 1'b0;
      r_res   <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op  <= in_op;
          r_a   <= in_a;
          r_b   <= in_b;
          r_cnt <= '0;
        end
        S_ABS_A: begin
          if (w_sdiv && r_a[31]) r_a <= alu_result;
          r_sa <= w_sdiv & r_a[31];
        end
        S_ABS_B: begin
          r_b  <= w_bnew;
          r_sb <= w_sdiv & r_b[31];
          r_bz <= (r_b == '0);
          r_lo <= w_is_mul ? w_bnew : r_a;
          r_hi <= '0;
        end
        S_ITER: begin
          r_cnt <= r_cnt + 6'd1;
          if (w_is_mul) begin
            r_hi <= {alu_carry, alu_result[31:1]};
            r_lo <= {alu_result[0], r_lo[31:1]};
          end else begin
            r_hi <= w_q ? alu_result : w_sh;
            r_lo <= {r_lo[30:0], w_q};
          end
        end
        S_FIX: begin
          r_res <= w_fix_ill ? '0 : (w_fix_neg ? alu_result : w_fix_val);
          r_ill <= w_fix_ill;
        end
        default: ;
      endcase
    end
  end

endmodule
